// File: rtl/led_display_pkg.sv
// Shared types and helpers for the LED value scanner.
package led_display_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHOW      = 2'd1,
        GAP       = 2'd2,
        FRAME_GAP = 2'd3
    } scan_state_e;

    function automatic int unsigned nibbles(input int unsigned value_w);
        return value_w / NIBBLE_W;
    endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// Free-running PWM counter that blanks the LED drive outside the brightness duty window.
// Compiled only when LED_PWM_EN is defined.
`ifdef LED_PWM_EN
module led_pwm_gate #(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned LED_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] brightness_i,
    input  logic [LED_W-1:0]    leds_raw,
    input  logic                pos_raw,
    output logic [LED_W-1:0]    leds_gated_c,
    output logic                pos_gated_c
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                on_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // brightness 0 never lights; full scale gives (2^B-1)/2^B duty
    assign on_c         = (pwm_cnt < brightness_i);
    assign leds_gated_c = on_c ? leds_raw : '0;
    assign pos_gated_c  = on_c & pos_raw;

endmodule
`endif

// File: rtl/led_value_scanner.sv
// Serialises a word onto 4 LEDs one nibble at a time, MSB nibble first, with inter-nibble and frame gaps.
// Optional LED_PWM_EN adds a brightness_i port and PWM gating of the LED outputs.
module led_value_scanner
    import led_display_pkg::*;
#(
    parameter int unsigned VALUE_W   = 32,
    parameter int unsigned DWELL_CYC = 6_000_000,
    parameter int unsigned GAP_CYC   = 3_000_000,
    parameter int unsigned PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [VALUE_W-1:0]  value_i,
    input  logic                value_valid_i,
    output logic                value_ready_o,
    output logic [NIBBLE_W-1:0] leds_o,
    output logic                led_pos_o,
    output logic                frame_done_o
`ifdef LED_PWM_EN
    ,
    input  logic [PWM_BITS-1:0] brightness_i
`endif
);

    localparam int unsigned NIB     = nibbles(VALUE_W);
    localparam int unsigned IDX_W   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned CNT_MAX = (DWELL_CYC > 2 * GAP_CYC) ? DWELL_CYC : 2 * GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] FGAP_LAST  = CNT_W'(2 * GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NIB - 1);

    generate
        if ((VALUE_W < NIBBLE_W) || ((VALUE_W % NIBBLE_W) != 0)) begin : g_bad_value_w
            $error("led_value_scanner: VALUE_W must be a multiple of 4 and at least 4");
        end
        if (DWELL_CYC < 1) begin : g_bad_dwell
            $error("led_value_scanner: DWELL_CYC must be at least 1");
        end
        if (PWM_BITS < 1) begin : g_bad_pwm
            $error("led_value_scanner: PWM_BITS must be at least 1");
        end
    endgenerate

    scan_state_e          state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [VALUE_W-1:0]   shadow, disp;
    logic                 has_value;
    logic                 pending_c, accept_c, snap_c, done_c, pos_c;
    logic [NIBBLE_W-1:0]  nibble_c, leds_c, leds_g_c;
    logic                 pos_g_c;

    // ready is the registered inverse of the shadow-buffer occupancy
    assign pending_c = ~value_ready_o;
    assign accept_c  = value_valid_i & value_ready_o;
    assign nibble_c  = NIBBLE_W'(disp >> (NIBBLE_W * (NIB - 1 - 32'(idx))));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        snap_c    = 1'b0;
        done_c    = 1'b0;
        leds_c    = '0;
        pos_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i && (pending_c || has_value)) begin
                    state_nxt = SHOW;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    snap_c    = pending_c;
                end
            end
            SHOW: begin
                leds_c = nibble_c;
                pos_c  = (idx == '0);
                if (cnt == DWELL_LAST) begin
                    cnt_nxt = '0;
                    if (GAP_CYC != 0) begin
                        state_nxt = GAP;
                    end else if (idx == IDX_LAST) begin
                        // zero-gap build: next frame starts straight after the last nibble
                        done_c  = 1'b1;
                        idx_nxt = '0;
                        snap_c  = pending_c;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        done_c    = 1'b1;
                        state_nxt = FRAME_GAP;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = SHOW;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FRAME_GAP: begin
                if (cnt == FGAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                    idx_nxt   = '0;
                    snap_c    = pending_c;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // disable aborts the frame silently; shadow contents survive
        if ((state != IDLE) && !enable_i) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            snap_c    = 1'b0;
            done_c    = 1'b0;
            leds_c    = '0;
            pos_c     = 1'b0;
        end
    end

`ifdef LED_PWM_EN
    led_pwm_gate #(
        .PWM_BITS (PWM_BITS),
        .LED_W    (NIBBLE_W)
    ) u_pwm_gate (
        .clk          (clk),
        .rst_n        (rst_n),
        .brightness_i (brightness_i),
        .leds_raw     (leds_c),
        .pos_raw      (pos_c),
        .leds_gated_c (leds_g_c),
        .pos_gated_c  (pos_g_c)
    );
`else
    assign leds_g_c = leds_c;
    assign pos_g_c  = pos_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            shadow        <= '0;
            disp          <= '0;
            has_value     <= 1'b0;
            value_ready_o <= 1'b1;
            leds_o        <= '0;
            led_pos_o     <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            leds_o       <= leds_g_c;
            led_pos_o    <= pos_g_c;
            frame_done_o <= done_c;
            if (snap_c) begin
                disp      <= shadow;
                has_value <= 1'b1;
            end
            // accept and snapshot are exclusive: accept needs an empty buffer, snapshot a full one
            if (accept_c) begin
                shadow        <= value_i;
                value_ready_o <= 1'b0;
            end else if (snap_c) begin
                value_ready_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_value_scanner.sv
// Self-checking bench for led_value_scanner: a 16-bit/4/2 instance and a zero-gap instance.
module tb_led_value_scanner;

    localparam int VW      = 16;
    localparam int NIB     = 4;
    localparam int D       = 4;
    localparam int G       = 2;
    localparam int FRAME_A = NIB * (D + G) + 2 * G;
    localparam int FRAME_B = NIB * D;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en_a, vld_a, rdy_a, pos_a, done_a;
    logic [VW-1:0] val_a;
    logic [3:0]    leds_a;
    logic          en_b, vld_b, rdy_b, pos_b, done_b;
    logic [VW-1:0] val_b;
    logic [3:0]    leds_b;
`ifdef LED_PWM_EN
    logic [3:0]    bright_a = 4'hF;
    logic [3:0]    bright_b = 4'hF;
`endif

    always #5 clk = ~clk;

    led_value_scanner #(.VALUE_W(VW), .DWELL_CYC(D), .GAP_CYC(G), .PWM_BITS(4)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (en_a),
        .value_i       (val_a),
        .value_valid_i (vld_a),
        .value_ready_o (rdy_a),
        .leds_o        (leds_a),
        .led_pos_o     (pos_a),
        .frame_done_o  (done_a)
`ifdef LED_PWM_EN
        ,.brightness_i (bright_a)
`endif
    );

    led_value_scanner #(.VALUE_W(VW), .DWELL_CYC(D), .GAP_CYC(0), .PWM_BITS(4)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (en_b),
        .value_i       (val_b),
        .value_valid_i (vld_b),
        .value_ready_o (rdy_b),
        .leds_o        (leds_b),
        .led_pos_o     (pos_b),
        .frame_done_o  (done_b)
`ifdef LED_PWM_EN
        ,.brightness_i (bright_b)
`endif
    );

    int            cyc = 0;
    int            n_assert = 0;
    int            n_fail = 0;
    int            a_mode, b_mode;
    int            origin_a, origin_b;
    logic [VW-1:0] fv [0:63];
    logic [VW-1:0] val_b_exp;
    bit            want_a;
    logic [VW-1:0] push_a;
    int            acc_a;
    bit            acc_a_flag;
    int            fd_cnt;
    logic [VW-1:0] v;

    // expected {frame_done, led_pos, leds} at cycle t of a display that began at t=0
    function automatic logic [5:0] expect_out(input int t, input logic [VW-1:0] val, input int d, input int g);
        int            slot_len, body, off, slot, r;
        logic [VW-1:0] sh;
        logic [5:0]    res;
        res      = '0;
        slot_len = d + g;
        body     = NIB * slot_len;
        if (t >= 0) begin
            off = t % (body + 2 * g);
            if (off < body) begin
                slot   = off / slot_len;
                r      = off % slot_len;
                res[5] = (off == body - 1);
                if (r < d) begin
                    sh       = val >> (4 * (NIB - 1 - slot));
                    res[3:0] = sh[3:0];
                    res[4]   = (slot == 0);
                end
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic fill(input logic [VW-1:0] val);
        for (int i = 0; i < 64; i++) fv[i] = val;
    endtask

    // one clock: drive pending push, record acceptance, compare both DUTs to the model
    task automatic step();
        logic       rdy_seen;
        logic [5:0] e;
        int         t, k, x;
        vld_a    = want_a;
        val_a    = push_a;
        rdy_seen = rdy_a;
        @(posedge clk);
        #1;
        cyc++;
        if (want_a && rdy_seen) begin
            want_a     = 1'b0;
            vld_a      = 1'b0;
            acc_a      = cyc;
            acc_a_flag = 1'b1;
            if (a_mode == 2) begin
                x = acc_a - origin_a + 1;
                k = (x < 0) ? 0 : (x / FRAME_A) + 1;
                for (int i = k; i < 64; i++) fv[i] = push_a;
            end
        end
        if (a_mode != 0) begin
            e = '0;
            if (a_mode == 2) begin
                t = cyc - origin_a;
                k = (t < 0) ? 0 : t / FRAME_A;
                if (k > 63) k = 63;
                e = expect_out(t, fv[k], D, G);
            end
            chk("a_leds", 32'(leds_a), 32'(e[3:0]));
            chk("a_pos", 32'(pos_a), 32'(e[4]));
            chk("a_frame_done", 32'(done_a), 32'(e[5]));
        end
        if (b_mode != 0) begin
            e = (b_mode == 2) ? expect_out(cyc - origin_b, val_b_exp, D, 0) : 6'd0;
            chk("b_leds", 32'(leds_b), 32'(e[3:0]));
            chk("b_pos", 32'(pos_b), 32'(e[4]));
            chk("b_frame_done", 32'(done_b), 32'(e[5]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_wait(input logic [VW-1:0] val);
        push_a     = val;
        want_a     = 1'b1;
        acc_a_flag = 1'b0;
        for (int i = 0; i < 200 && !acc_a_flag; i++) step();
        want_a = 1'b0;
        chk("push_accepted", 32'(acc_a_flag), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        en_a = 1'b1; en_b = 1'b1;
        vld_a = 1'b0; vld_b = 1'b0; val_a = '0; val_b = '0;
        want_a = 1'b0; push_a = '0; acc_a = 0; acc_a_flag = 1'b0;
        a_mode = 0; b_mode = 0; origin_a = 0; origin_b = 0; val_b_exp = '0;
        fill('0);

        // reset values
        #1 rst_n = 1'b0;
        #11;
        chk("rst_leds_a", 32'(leds_a), 32'd0);
        chk("rst_pos_a", 32'(pos_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_ready_a", 32'(rdy_a), 32'd1);
        chk("rst_leds_b", 32'(leds_b), 32'd0);
        chk("rst_ready_b", 32'(rdy_b), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_mode = 1; b_mode = 1;
        run(6);

        // 0xBEEF: two full frames
        push_wait(16'hBEEF);
        origin_a = acc_a + 2;
        fill(16'hBEEF);
        a_mode = 2;
        run(2);
        chk("t1_first_nibble", 32'(leds_a), 32'hB);
        chk("t1_first_pos", 32'(pos_a), 32'd1);
        fd_cnt = 0;
        for (int i = 0; i < 2 * FRAME_A; i++) begin
            step();
            fd_cnt += int'(done_a);
        end
        chk("t1_done_pulses", 32'(fd_cnt), 32'd2);

        // enable drop in the second nibble, then restart
        run(7);
        chk("t3_second_nibble", 32'(leds_a), 32'hE);
        en_a = 1'b0;
        a_mode = 1;
        run(13);
        en_a = 1'b1;
        origin_a = cyc + 2;
        a_mode = 2;
        run(2);
        chk("t3_restart_nibble", 32'(leds_a), 32'hB);
        chk("t3_restart_pos", 32'(pos_a), 32'd1);
        run(FRAME_A - 1);

        // reset mid-SHOW with a value pending
        run(2);
        acc_a_flag = 1'b0;
        push_a = 16'($urandom);
        want_a = 1'b1;
        step();
        chk("t4_push_taken", 32'(acc_a_flag), 32'd1);
        chk("t4_ready_low", 32'(rdy_a), 32'd0);
        chk("t4_lit_before_reset", 32'(leds_a), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_leds", 32'(leds_a), 32'd0);
        chk("t4_async_pos", 32'(pos_a), 32'd0);
        chk("t4_async_done", 32'(done_a), 32'd0);
        chk("t4_async_ready", 32'(rdy_a), 32'd1);
        a_mode = 1;
        run(2);
        rst_n = 1'b1;
        run(40);

        // back-to-back pushes: second taken at frame start, third stalls a frame
        push_wait(16'h1234);
        origin_a = acc_a + 2;
        fill(16'h1234);
        a_mode = 2;
        push_wait(16'hABCD);
        chk("t2_second_accept_cycle", 32'(acc_a), 32'(origin_a));
        chk("t2_ready_low", 32'(rdy_a), 32'd0);
        push_wait(16'($urandom));
        chk("t2_third_accept_cycle", 32'(acc_a), 32'(origin_a + FRAME_A));
        run(origin_a + 3 * FRAME_A + 2 - cyc);

        // random values pushed at random points while scanning
        for (int j = 0; j < 4; j++) begin
            run(int'($urandom_range(0, 35)));
            case (j)
                1:       v = 16'h0000;
                2:       v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            push_wait(v);
        end
        run(2 * FRAME_A + 2);

        // zero-gap instance: 0x00F0 back-to-back, 16-cycle frame
        vld_b = 1'b1;
        val_b = 16'h00F0;
        step();
        vld_b = 1'b0;
        chk("t5_ready_low", 32'(rdy_b), 32'd0);
        origin_b = cyc + 2;
        val_b_exp = 16'h00F0;
        b_mode = 2;
        run(2);
        chk("t5_first_pos", 32'(pos_b), 32'd1);
        chk("t5_first_nibble", 32'(leds_b), 32'd0);
        run(8);
        chk("t5_third_nibble", 32'(leds_b), 32'hF);
        fd_cnt = 0;
        for (int i = 0; i < 2 * FRAME_B; i++) begin
            step();
            fd_cnt += int'(done_b);
        end
        chk("t5_done_pulses", 32'(fd_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
